// File: rtl/sipo_deser.sv
// Serial-in/parallel-out word receiver, MSB first, with a one-entry valid/ready output buffer.
// Build option: define SIPO_PARITY_EN to append one even-parity bit per frame (reported on out_perr).
module sipo_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_ovf;
  logic [WIDTH-1:0] w_word;
  logic             w_commit;
  logic             w_accept;
  logic             w_drain;

`ifdef SIPO_PARITY_EN
  localparam logic [0:0] S_RECV = 1'b0;
  localparam logic [0:0] S_PAR  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic             r_perr;
  logic [WIDTH-1:0] w_shift;
  logic             w_perr;

  // The data word is already complete in r_sh while the parity bit arrives.
  assign w_shift  = {r_sh[WIDTH-2:0], din};
  assign w_commit = din_valid && (r_state == S_PAR);
  assign w_word   = r_sh;
  assign w_perr   = ^{r_sh, din};
  assign out_perr = r_perr;
`else
  // Only WIDTH-1 bits need storing: the final bit joins the word combinationally on commit.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] w_shift;

  assign w_shift  = {r_sh, din};
  assign w_commit = din_valid && (r_cnt == LAST);
  assign w_word   = w_shift;
  assign out_perr = 1'b0;
`endif

  assign w_drain  = r_out_valid && out_ready;
  assign w_accept = w_commit && (!r_out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh        <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_state     <= S_RECV;
      r_perr      <= 1'b0;
`endif
    end else begin
      if (din_valid) begin
`ifdef SIPO_PARITY_EN
        if (r_state == S_PAR) begin
          r_state <= S_RECV;
          r_cnt   <= '0;
        end else begin
          r_sh <= w_shift;
          if (r_cnt == LAST) begin
            r_state <= S_PAR;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`else
        r_sh  <= w_shift[WIDTH-2:0];
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
`endif
      end

      if (w_accept) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        r_perr      <= w_perr;
`endif
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      // A dropped word outranks a clear in the same cycle.
      if (w_commit && !w_accept) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;

endmodule
